// File: rtl/pipe_stall_ctrl.sv
// Pipeline interlock for the F/D/E registers of the 5-stage core.
// Holds a shadow scoreboard of in-flight E/M destinations and the MD busy countdown.
module pipe_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CW          = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_valid,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic [4:0]  d_wa,
  input  logic [1:0]  d_tnew,
  input  logic        d_md_use,
  input  logic        d_md_start,
  input  logic        d_md_div,
  output logic        f_we,
  output logic        d_we,
  output logic        e_flush,
  output logic        md_busy,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0]    TUSE_NONE = 2'd3;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [15:0]   CNT_MAX   = 16'hFFFF;

  logic [4:0]    e_wa;
  logic [1:0]    e_tnew;
  logic [4:0]    m_wa;
  logic [1:0]    m_tnew;
  logic [CW-1:0] md_cnt;

  logic          hz_rs;
  logic          hz_rt;
  logic          hz_md;
  logic          stall;
  logic          md_load;
  logic [1:0]    m_tnew_nxt;

  // A source is only hazardous when the producer's result is not yet
  // forwardable by the time this instruction needs it; $0 is never tracked.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] ewa,
    input logic [1:0] etnew,
    input logic [4:0] mwa,
    input logic [1:0] mtnew
  );
    logic hit_e;
    logic hit_m;
    hit_e = (src == ewa) && (etnew > tuse);
    hit_m = (src == mwa) && (mtnew > tuse);
    return (tuse != TUSE_NONE) && (src != 5'd0) && (hit_e || hit_m);
  endfunction

  always_comb begin
    hz_rs = d_valid && src_hazard(d_rs, d_tuse_rs, e_wa, e_tnew, m_wa, m_tnew);
    hz_rt = d_valid && src_hazard(d_rt, d_tuse_rt, e_wa, e_tnew, m_wa, m_tnew);
    hz_md = d_valid && d_md_use && (md_cnt != '0);
    stall = hz_rs || hz_rt || hz_md;
  end

  assign md_load    = !stall && d_valid && d_md_start;
  assign m_tnew_nxt = (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;

  // Reset holds the fetch/decode registers and keeps flushing E.
  assign f_we    = reset && !stall;
  assign d_we    = reset && !stall;
  assign e_flush = !reset || stall;
  assign md_busy = (md_cnt != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_wa   <= 5'd0;
      e_tnew <= 2'd0;
      m_wa   <= 5'd0;
      m_tnew <= 2'd0;
    end else begin
      m_wa   <= e_wa;
      m_tnew <= m_tnew_nxt;
      if (stall || !d_valid) begin
        e_wa   <= 5'd0;
        e_tnew <= 2'd0;
      end else begin
        e_wa   <= d_wa;
        e_tnew <= d_tnew;
      end
    end
  end

  // Busy countdown starts the edge the MD instr enters E, so md_busy is
  // high for exactly MULT_CYCLES/DIV_CYCLES cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt <= '0;
    end else if (md_load) begin
      md_cnt <= d_md_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 16'd0;
    end else if (stall && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed scoreboard bench for pipe_stall_ctrl: each driven cycle pushes its
// hand-derived expected stall/busy, popped and compared on the falling edge.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [1:0]  d_tuse_rs;
  logic [1:0]  d_tuse_rt;
  logic [4:0]  d_wa;
  logic [1:0]  d_tnew;
  logic        d_md_use;
  logic        d_md_start;
  logic        d_md_div;
  logic        f_we;
  logic        d_we;
  logic        e_flush;
  logic        md_busy;
  logic [15:0] stall_cnt;

  typedef struct {
    logic        stall;
    logic        busy;
    logic [15:0] cnt;
    int          id;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc_id  = 0;
  logic [15:0] sc_model = 16'd0;
  logic [15:0] sat_base;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .d_valid    (d_valid),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_wa       (d_wa),
    .d_tnew     (d_tnew),
    .d_md_use   (d_md_use),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .f_we       (f_we),
    .d_we       (d_we),
    .e_flush    (e_flush),
    .md_busy    (md_busy),
    .stall_cnt  (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs, input logic [1:0] trs,
                        input logic [4:0] rt, input logic [1:0] trt,
                        input logic [4:0] wa, input logic [1:0] tnew,
                        input logic mu, input logic ms, input logic md);
    d_valid = v;  d_rs = rs; d_tuse_rs = trs; d_rt = rt; d_tuse_rt = trt;
    d_wa = wa;    d_tnew = tnew; d_md_use = mu; d_md_start = ms; d_md_div = md;
  endtask

  // One D-stage cycle with its expected stall and md_busy.
  task automatic cyc(input logic v, input logic [4:0] rs, input logic [1:0] trs,
                     input logic [4:0] rt, input logic [1:0] trt,
                     input logic [4:0] wa, input logic [1:0] tnew,
                     input logic mu, input logic ms, input logic md,
                     input logic xs, input logic xb);
    exp_t e;
    @(posedge clk);
    #1;
    set_in(v, rs, trs, rt, trt, wa, tnew, mu, ms, md);
    e.stall = xs; e.busy = xb; e.cnt = sc_model; e.id = cyc_id;
    exp_q.push_back(e);
    cyc_id++;
    if (xs && sc_model != 16'hFFFF) sc_model = sc_model + 16'd1;
  endtask

  task automatic bub(input logic xb);
    cyc(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, xb);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("c%0d.f_we", e.id),      32'(f_we),      32'(!e.stall));
      check($sformatf("c%0d.d_we", e.id),      32'(d_we),      32'(!e.stall));
      check($sformatf("c%0d.e_flush", e.id),   32'(e_flush),   32'(e.stall));
      check($sformatf("c%0d.md_busy", e.id),   32'(md_busy),   32'(e.busy));
      check($sformatf("c%0d.stall_cnt", e.id), 32'(stall_cnt), 32'(e.cnt));
    end
  end

  initial begin
    reset = 1'b0;
    set_in(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #12;
    check("rst.f_we", 32'(f_we), 32'd0);
    check("rst.d_we", 32'(d_we), 32'd0);
    check("rst.e_flush", 32'(e_flush), 32'd1);
    check("rst.md_busy", 32'(md_busy), 32'd0);
    check("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // mult then mflo: 5 stalls while busy, then advance
    cyc(1, 0, 3, 0, 3, 0, 0, 1, 1, 0, 0, 0);
    repeat (5) cyc(1, 0, 3, 0, 3, 8, 0, 1, 0, 0, 1, 1);
    cyc(1, 0, 3, 0, 3, 8, 0, 1, 0, 0, 0, 0);
    bub(0); bub(0);
    @(negedge clk); #1;
    check("mult.stall_cnt", 32'(stall_cnt), 32'd5);

    // lw $t0 then addu reading $t0 at tuse 1: one stall
    cyc(1, 0, 3, 0, 3, 8, 2, 0, 0, 0, 0, 0);
    cyc(1, 8, 1, 0, 3, 9, 1, 0, 0, 0, 1, 0);
    cyc(1, 8, 1, 0, 3, 9, 1, 0, 0, 0, 0, 0);
    bub(0); bub(0);

    // addu tnew 1 then beq tuse 0: one stall
    cyc(1, 0, 3, 0, 3, 8, 1, 0, 0, 0, 0, 0);
    cyc(1, 8, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 8, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    bub(0); bub(0);

    // same pair with tuse 1: forwarding covers it
    cyc(1, 0, 3, 0, 3, 8, 1, 0, 0, 0, 0, 0);
    cyc(1, 8, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    bub(0); bub(0);

    // lw then rt read at tuse 0: stalls on E, then on M
    cyc(1, 0, 3, 0, 3, 9, 2, 0, 0, 0, 0, 0);
    cyc(1, 0, 3, 9, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 3, 9, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 3, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    bub(0); bub(0);

    // matching register but tuse 3 (not read): no stall
    cyc(1, 0, 3, 0, 3, 9, 2, 0, 0, 0, 0, 0);
    cyc(1, 9, 3, 9, 3, 10, 1, 0, 0, 0, 0, 0);
    bub(0); bub(0);

    // matching register in a bubble slot: no stall
    cyc(1, 0, 3, 0, 3, 9, 2, 0, 0, 0, 0, 0);
    cyc(0, 9, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    bub(0); bub(0);

    // write to $0 then read $0 on both sources: never stalls
    cyc(1, 0, 3, 0, 3, 0, 2, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    bub(0); bub(0);

    // div then mfhi: 10 stalls
    cyc(1, 0, 3, 0, 3, 0, 0, 1, 1, 1, 0, 0);
    repeat (10) cyc(1, 0, 3, 0, 3, 8, 0, 1, 0, 0, 1, 1);
    cyc(1, 0, 3, 0, 3, 8, 0, 1, 0, 0, 0, 0);
    bub(0); bub(0);

    // div then unrelated addu ops: busy but not stalled
    cyc(1, 0, 3, 0, 3, 0, 0, 1, 1, 1, 0, 0);
    cyc(1, 3, 1, 0, 3, 4, 1, 0, 0, 0, 0, 1);
    cyc(1, 5, 1, 6, 1, 7, 1, 0, 0, 0, 0, 1);
    repeat (8) bub(1);
    bub(0);

    // reset mid-div when the countdown reaches 6
    cyc(1, 0, 3, 0, 3, 0, 0, 1, 1, 1, 0, 0);
    repeat (4) bub(1);
    @(posedge clk); #1;
    set_in(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("pre_rst.md_busy", 32'(md_busy), 32'd1);
    check("pre_rst.stall_cnt", 32'(stall_cnt), 32'(sc_model));
    reset = 1'b0;
    #1;
    check("mid_rst.md_busy", 32'(md_busy), 32'd0);
    check("mid_rst.e_flush", 32'(e_flush), 32'd1);
    check("mid_rst.f_we", 32'(f_we), 32'd0);
    check("mid_rst.d_we", 32'(d_we), 32'd0);
    check("mid_rst.stall_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sc_model = 16'd0;
    bub(0);
    // mfhi right after reset must not wait on the aborted divide
    cyc(1, 0, 3, 0, 3, 8, 0, 1, 0, 0, 0, 0);
    bub(0); bub(0);
    @(negedge clk); #1;
    check("post_rst.stall_cnt", 32'(stall_cnt), 32'd0);

    // back-to-back divs: 10 stalls per 11 cycles, then saturation
    sat_base = stall_cnt;
    @(posedge clk); #1;
    set_in(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    repeat (110) @(posedge clk);
    #1;
    check("divloop.stall_cnt", 32'(stall_cnt), 32'(sat_base) + 32'd100);
    repeat (72100) @(posedge clk);
    #1;
    check("sat.stall_cnt", 32'(stall_cnt), 32'hFFFF);
    repeat (30) @(posedge clk);
    #1;
    check("sat_hold.stall_cnt", 32'(stall_cnt), 32'hFFFF);
    set_in(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
